// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU memory request engine.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } lsu_state_e;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Unsupported encodings are folded into the misaligned case so they never reach the bus.
    function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                            input logic       is_store,
                                            input logic [1:0] off);
        logic bad_s;
        bad_s = 1'b1;
        if (is_store) begin
            case (funct3)
                FUNCT3_SB: bad_s = 1'b0;
                FUNCT3_SH: bad_s = (off == 2'd3);
                FUNCT3_SW: bad_s = (off != 2'd0);
                default:   bad_s = 1'b1;
            endcase
        end else begin
            case (funct3)
                FUNCT3_LB, FUNCT3_LBU: bad_s = 1'b0;
                FUNCT3_LH, FUNCT3_LHU: bad_s = (off == 2'd3);
                FUNCT3_LW:             bad_s = (off != 2'd0);
                default:               bad_s = 1'b1;
            endcase
        end
        return bad_s;
    endfunction

endpackage

// File: rtl/lsu_mem_req_if.sv
// Request/result handshakes plus the AXI4-Lite master channels of the LSU.
interface lsu_mem_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_W-1:0]     in_addr;
    logic [DATA_W-1:0]     in_wdata;
    logic [2:0]            in_funct3;
    logic                  in_is_store;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_raw_data;
    logic [ADDR_W-1:0]     out_addr;
    logic [2:0]            out_funct3;
    logic                  out_is_store;
    logic                  out_err;

    logic [ADDR_W-1:0]     araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    logic [ADDR_W-1:0]     awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        input  in_valid, in_addr, in_wdata, in_funct3, in_is_store,
        output in_ready,
        output out_valid, out_raw_data, out_addr, out_funct3, out_is_store, out_err,
        input  out_ready,
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        output in_valid, in_addr, in_wdata, in_funct3, in_is_store,
        input  in_ready,
        input  out_valid, out_raw_data, out_addr, out_funct3, out_is_store, out_err,
        output out_ready,
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/lsu_store_align.sv
// Byte-lane placement of store data/strobe and access legality check.
module lsu_store_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wdata,
    input  logic              is_store,
    output logic [DATA_W-1:0] wdata_al,
    output logic [3:0]        wstrb,
    output logic              misalign
);

    // Shift data into its lanes and build the strobe for legal stores only
    always_comb begin
        wdata_al = wdata << {addr, 3'b000};
        misalign = lsu_misaligned(funct3, is_store, addr);
        wstrb    = 4'b0000;
        if (is_store && !misalign) begin
            case (funct3)
                FUNCT3_SB: wstrb = 4'b0001 << addr;
                FUNCT3_SH: wstrb = 4'b0011 << addr;
                FUNCT3_SW: wstrb = 4'b1111;
                default:   wstrb = 4'b0000;
            endcase
        end else begin
            wstrb = 4'b0000;
        end
    end

endmodule

// File: rtl/lsu_mem_req.sv
// LSU memory request engine: one EXU request becomes a single AXI4-Lite read or
// write, and the raw bus word is held until the consumer accepts it.
module lsu_mem_req
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_req_if.master bus
);

    lsu_state_e            state_r;
    lsu_state_e            state_n_s;
    logic                  in_ready_r;
    logic                  accept_s;
    logic [ADDR_W-1:0]     addr_r;
    logic [2:0]            funct3_r;
    logic                  is_store_r;
    logic [DATA_W-1:0]     wdata_r;
    logic [DATA_W/8-1:0]   wstrb_r;
    logic [DATA_W-1:0]     raw_r;
    logic [DATA_W-1:0]     raw_n_s;
    logic                  err_r;
    logic                  err_n_s;
    logic                  aw_done_r;
    logic                  aw_done_n_s;
    logic                  w_done_r;
    logic                  w_done_n_s;
    logic [DATA_W-1:0]     al_wdata_s;
    logic [3:0]            al_wstrb_s;
    logic                  misalign_s;

    lsu_store_align #(.DATA_W(DATA_W)) u_align (
        .addr     (bus.in_addr[1:0]),
        .funct3   (bus.in_funct3),
        .wdata    (bus.in_wdata),
        .is_store (bus.in_is_store),
        .wdata_al (al_wdata_s),
        .wstrb    (al_wstrb_s),
        .misalign (misalign_s)
    );

    assign accept_s = bus.in_valid & in_ready_r;

    // Next-state and result computation
    always_comb begin
        state_n_s   = state_r;
        raw_n_s     = raw_r;
        err_n_s     = err_r;
        aw_done_n_s = aw_done_r;
        w_done_n_s  = w_done_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    raw_n_s     = '0;
                    err_n_s     = 1'b0;
                    aw_done_n_s = 1'b0;
                    w_done_n_s  = 1'b0;
                    if (misalign_s) begin
                        state_n_s = DONE;
                        err_n_s   = 1'b1;
                    end else if (bus.in_is_store) begin
                        state_n_s = WR_REQ;
                    end else begin
                        state_n_s = RD_ADDR;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            RD_ADDR: begin
                if (bus.arready) begin
                    state_n_s = RD_DATA;
                end else begin
                    state_n_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (bus.rvalid) begin
                    raw_n_s   = bus.rdata;
                    err_n_s   = (bus.rresp != RESP_OKAY);
                    state_n_s = DONE;
                end else begin
                    state_n_s = RD_DATA;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; either may finish first or both together
                aw_done_n_s = aw_done_r | bus.awready;
                w_done_n_s  = w_done_r | bus.wready;
                if (aw_done_n_s && w_done_n_s) begin
                    state_n_s = WR_RESP;
                end else begin
                    state_n_s = WR_REQ;
                end
            end
            WR_RESP: begin
                if (bus.bvalid) begin
                    raw_n_s   = '0;
                    err_n_s   = (bus.bresp != RESP_OKAY);
                    state_n_s = DONE;
                end else begin
                    state_n_s = WR_RESP;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = DONE;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State register; in_ready is registered so it stays low while reset is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            in_ready_r <= (state_n_s == IDLE);
        end
    end

    // Request capture on acceptance and result/handshake bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r     <= '0;
            funct3_r   <= 3'b000;
            is_store_r <= 1'b0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            raw_r      <= '0;
            err_r      <= 1'b0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                addr_r     <= bus.in_addr;
                funct3_r   <= bus.in_funct3;
                is_store_r <= bus.in_is_store;
                wdata_r    <= al_wdata_s;
                wstrb_r    <= al_wstrb_s;
            end
            raw_r     <= raw_n_s;
            err_r     <= err_n_s;
            aw_done_r <= aw_done_n_s;
            w_done_r  <= w_done_n_s;
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.out_valid    = (state_r == DONE);
    assign bus.out_raw_data = raw_r;
    assign bus.out_addr     = addr_r;
    assign bus.out_funct3   = funct3_r;
    assign bus.out_is_store = is_store_r;
    assign bus.out_err      = err_r;

    assign bus.araddr  = {addr_r[ADDR_W-1:2], 2'b00};
    assign bus.arvalid = (state_r == RD_ADDR);
    assign bus.rready  = (state_r == RD_DATA);

    assign bus.awaddr  = {addr_r[ADDR_W-1:2], 2'b00};
    assign bus.awvalid = (state_r == WR_REQ) && !aw_done_r;
    assign bus.wdata   = wdata_r;
    assign bus.wstrb   = wstrb_r;
    assign bus.wvalid  = (state_r == WR_REQ) && !w_done_r;
    assign bus.bready  = (state_r == WR_RESP);

endmodule
